pc_predict: RTL and testbench

- Next-generation program-counter unit for the RV32/RV64 core fetch stage.
- Holds the fetch PC and adds pipeline stall and trap redirect.
- Adds execute-stage misprediction recovery and a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Supplies the predicted next PC each cycle; execute resolves branches and reports them back.

---
 rtl/pc_predict.sv | 143 ++++++++++++++
 tb/tb_pc_predict.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict.sv
// Fetch program counter with a direct-mapped BTB, stall, trap redirect and execute-stage mispredict recovery.
// Latency: pc is registered; pred_taken, pred_target, flush and misalign are combinational in the same cycle.
// Backpressure: stall holds pc. Trap and mispredict redirects override stall. BTB training ignores stall.
module pc_predict #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET       = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            flush,
    output logic            misalign
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    // fetch pc
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;

    // BTB storage; only the valid bits are reset, the payload is qualified by them
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    // lookup side (indexed by fetch pc)
    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;

    // update side (indexed by resolved ex_pc)
    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic            mispredict;
    logic            btb_wr;
    logic [1:0]      ctr_d;
    logic [XLEN-1:0] target_d;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc       = pc_q;
    assign next_pc  = pc_plus4;

    assign lk_idx = pc_q[IDX+1:2];
    assign lk_tag = pc_q[XLEN-1:IDX+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup sees the pre-update array contents; a same-cycle write to this index is not bypassed.
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? target_q[lk_idx] : pc_plus4;

    assign mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                                     (ex_taken && (ex_target != ex_pred_target)));
    assign misalign   = ex_valid && ex_taken && (ex_target[1:0] != 2'b00);
    // A misaligned redirect is not taken here; the CSR block turns it into a trap later.
    assign flush      = trap_valid || (mispredict && !misalign);

    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Next fetch pc: trap, then recovery, then misalign hold, then stall, then prediction.
    always_comb begin
        pc_d = pc_plus4;
        if (trap_valid) begin
            pc_d = trap_target;
        end else if (mispredict && !misalign) begin
            pc_d = ex_taken ? ex_target : (ex_pc + XLEN'(4));
        end else if (mispredict) begin
            pc_d = pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Fetch pc register; reset forces RESET immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB training: saturating counter on hit, allocate weakly-taken on a taken miss.
    always_comb begin
        btb_wr   = 1'b0;
        ctr_d    = ctr_q[ex_idx];
        target_d = target_q[ex_idx];
        if (ex_valid && !misalign) begin
            if (ex_hit) begin
                btb_wr = 1'b1;
                if (ex_taken) begin
                    ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                    target_d = ex_target;
                end else begin
                    ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                btb_wr   = 1'b1;
                ctr_d    = 2'b10;
                target_d = ex_target;
            end
        end
    end

    // Valid bits: cleared by reset, set on any write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (btb_wr) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    // BTB payload write (tag, target, counter).
    always_ff @(posedge clock) begin
        if (btb_wr) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_d;
            ctr_q[ex_idx]    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict with a reference model and an expectation queue.
// Latency: expectations are pushed when inputs are driven and popped at the following falling edge.
// Backpressure: stall, trap, mispredict and misalign paths are driven directly and also randomly.
module tb_pc_predict;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic        misalign;

    pc_predict #(
        .XLEN        (32),
        .RESET       (32'h0000_0100),
        .BTB_ENTRIES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .pc             (pc),
        .next_pc        (next_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .misalign       (misalign)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        flush;
        logic        misalign;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [31:0] m_pc;
    logic        m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [1:0]  m_ctr [16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h100;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    endtask

    task automatic set_in(input logic st, input logic tv, input logic [31:0] tt,
                          input logic ev, input logic [31:0] ep, input logic et,
                          input logic [31:0] etg, input logic ept, input logic [31:0] eptg);
        stall          = st;
        trap_valid     = tv;
        trap_target    = tt;
        ex_valid       = ev;
        ex_pc          = ep;
        ex_taken       = et;
        ex_target      = etg;
        ex_pred_taken  = ept;
        ex_pred_target = eptg;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic cycle();
        exp_t        e;
        exp_t        got;
        logic [3:0]  li;
        logic [3:0]  ui;
        logic        hit;
        logic        uhit;
        logic        mis;
        logic        mal;
        logic [31:0] npc;
        li  = m_pc[5:2];
        hit = m_v[li] && (m_tag[li] == m_pc[31:6]);
        mis = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
        mal = ex_valid && ex_taken && (ex_target[1:0] != 2'b00);
        e.pc          = m_pc;
        e.next_pc     = m_pc + 32'd4;
        e.pred_taken  = hit && m_ctr[li][1];
        e.pred_target = hit ? m_tgt[li] : m_pc + 32'd4;
        e.flush       = trap_valid || (mis && !mal);
        e.misalign    = mal;
        sb_q.push_back(e);

        if (trap_valid)         npc = trap_target;
        else if (mis && !mal)   npc = ex_taken ? ex_target : ex_pc + 32'd4;
        else if (mis)           npc = m_pc;
        else if (stall)         npc = m_pc;
        else if (e.pred_taken)  npc = e.pred_target;
        else                    npc = m_pc + 32'd4;

        #4;
        got = sb_q.pop_front();
        chk("pc",          pc,          got.pc);
        chk("next_pc",     next_pc,     got.next_pc);
        chk("pred_taken",  pred_taken,  got.pred_taken);
        chk("pred_target", pred_target, got.pred_target);
        chk("flush",       flush,       got.flush);
        chk("misalign",    misalign,    got.misalign);

        @(posedge clock);
        m_pc = npc;
        ui   = ex_pc[5:2];
        uhit = m_v[ui] && (m_tag[ui] == ex_pc[31:6]);
        if (ex_valid && !mal) begin
            if (uhit) begin
                if (ex_taken) begin
                    if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'b01;
                    m_tgt[ui] = ex_target;
                end else if (m_ctr[ui] != 2'b00) begin
                    m_ctr[ui] = m_ctr[ui] - 2'b01;
                end
            end else if (ex_taken) begin
                m_v[ui]   = 1'b1;
                m_tag[ui] = ex_pc[31:6];
                m_tgt[ui] = ex_target;
                m_ctr[ui] = 2'b10;
            end
        end
        #1;
    endtask

    task automatic do_trap(input logic [31:0] t);
        set_in(1'b0, 1'b1, t, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle_in();
    endtask

    task automatic resolve(input logic [31:0] ep, input logic et, input logic [31:0] etg,
                           input logic ept, input logic [31:0] eptg);
        set_in(1'b0, 1'b0, 32'h0, 1'b1, ep, et, etg, ept, eptg);
        cycle();
        idle_in();
    endtask

    logic [31:0] pc_set [6];
    logic [31:0] tg_set [6];

    initial begin
        reset = 1'b1;
        idle_in();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc",         pc,         32'h100);
        chk("rst_pred_taken", pred_taken, 1'b0);
        chk("rst_flush",      flush,      1'b0);
        chk("rst_misalign",   misalign,   1'b0);
        reset = 1'b0;

        // sequential fetch 0x100 -> 0x104 -> 0x108
        cycle();
        cycle();
        chk("seq_pc", pc, 32'h108);

        // stall three cycles, then trap during stall
        stall = 1'b1;
        repeat (3) cycle();
        chk("stall_pc", pc, 32'h108);
        set_in(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle_in();
        chk("trap_pc", pc, 32'h80);

        // mispredicted taken branch allocates, then a fetch at 0x200 predicts it
        resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        chk("recover_pc", pc, 32'h300);
        do_trap(32'h200);
        cycle();
        chk("btb_follow_pc", pc, 32'h300);

        // two not-taken resolves drive the counter to 00
        resolve(32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
        chk("nt_recover_pc", pc, 32'h204);
        resolve(32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
        do_trap(32'h200);
        cycle();
        chk("weak_nt_pc", pc, 32'h204);
        // one taken resolve is not enough, the second restores taken prediction
        resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        do_trap(32'h200);
        cycle();
        chk("one_taken_pc", pc, 32'h204);
        resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        do_trap(32'h200);
        cycle();
        chk("two_taken_pc", pc, 32'h300);

        // misaligned taken target: no flush, pc holds, no allocation
        resolve(32'h400, 1'b1, 32'h302, 1'b0, 32'h0);
        chk("misalign_hold_pc", pc, 32'h300);
        do_trap(32'h400);
        cycle();
        chk("misalign_no_alloc_pc", pc, 32'h404);

        // trap wins over mispredict, BTB still trained
        set_in(1'b0, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        cycle();
        idle_in();
        chk("trap_prio_pc", pc, 32'h80);
        do_trap(32'h500);
        // same-cycle lookup and update of one index: lookup sees old counter
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
        cycle();
        idle_in();
        // aliasing pc overwrites the entry
        resolve(32'h540, 1'b1, 32'h700, 1'b0, 32'h0);
        do_trap(32'h500);
        cycle();
        chk("alias_evict_pc", pc, 32'h504);

        // wrap-around of pc + 4
        do_trap(32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc", pc, 32'h0);

        // random traffic
        pc_set = '{32'h200, 32'h240, 32'h500, 32'h540, 32'h204, 32'h3C0};
        tg_set = '{32'h300, 32'h600, 32'h200, 32'h302, 32'h540, 32'h701};
        for (int k = 0; k < 300; k++) begin
            set_in(($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 15) == 0), pc_set[$urandom_range(0, 5)],
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0) ? m_pc : pc_set[$urandom_range(0, 5)],
                   1'($urandom_range(0, 1)), tg_set[$urandom_range(0, 5)],
                   1'($urandom_range(0, 1)), tg_set[$urandom_range(0, 5)]);
            cycle();
        end
        idle_in();

        // asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc",         pc,         32'h100);
        chk("async_rst_pred_taken", pred_taken, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        do_trap(32'h200);
        cycle();
        chk("post_rst_btb_empty_pc", pc, 32'h204);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
